alu_sweep_gen: RTL and testbench

ALU_SWEEP_GEN -- requirements
Module: alu_sweep_gen

---
 rtl/alu_sweep_gen.sv | 109 ++++++++++
 tb/tb_alu_sweep_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_gen.sv
// Exhaustive ALU sweep generator: steps op/a/b through every combination,
// waits SETTLE cycles per vector and streams {alu_flags, alu_o} out.
module alu_sweep_gen #(
  parameter int WIDTH         = 8,
  parameter int OP_BITS       = 5,
  parameter int SETTLE        = 10,
  parameter int OPS_PER_BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OP_BITS-1:0]   alu_op,
  input  logic [WIDTH-1:0]     alu_o,
  input  logic [7:0]           alu_flags,
  output logic [8+WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last_block,
  output logic [OP_BITS-1:0]   out_block,
  output logic                 busy,
  output logic                 done
);

  localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BLK_SH = $clog2(OPS_PER_BLOCK);
  localparam logic [OP_BITS-1:0] BLK_MASK = OP_BITS'(OPS_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_ADVANCE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          a_max, b_max, op_max, last_word, settle_done, done_nx;

  assign a_max     = &alu_a;
  assign b_max     = &alu_b;
  assign op_max    = &alu_op;
  assign last_word = a_max & b_max & op_max;

  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // abort overrides every other transition, including an EMIT transfer
  always_comb begin
    state_nx    = state;
    settle_done = 1'b0;
    done_nx     = 1'b0;
    case (state)
      S_IDLE:    if (start && !abort) state_nx = S_SETTLE;
      S_SETTLE:  if (abort) state_nx = S_IDLE;
                 else if (cnt == CW'(SETTLE - 1)) begin
                   settle_done = 1'b1;
                   state_nx    = S_EMIT;
                 end
      S_EMIT:    if (abort) state_nx = S_IDLE;
                 else if (out_ready) state_nx = S_ADVANCE;
      S_ADVANCE: if (abort) state_nx = S_IDLE;
                 else if (last_word) begin
                   state_nx = S_IDLE;
                   done_nx  = 1'b1;
                 end else state_nx = S_SETTLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      cnt            <= '0;
      out_data       <= '0;
      out_last_block <= 1'b0;
      out_block      <= '0;
      done           <= 1'b0;
    end else begin
      done <= done_nx;
      if (state == S_IDLE && start && !abort) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= '0;
        cnt    <= '0;
      end
      if (state == S_SETTLE && !abort) cnt <= cnt + 1'b1;
      if (settle_done) begin
        out_data       <= {alu_flags, alu_o};
        out_last_block <= a_max & b_max & ((alu_op & BLK_MASK) == BLK_MASK);
        out_block      <= alu_op >> BLK_SH;
      end
      // b innermost, op outermost; the final word never wraps op
      if (state == S_ADVANCE && !abort && !last_word) begin
        cnt   <= '0;
        alu_b <= alu_b + 1'b1;
        if (b_max) begin
          alu_a <= alu_a + 1'b1;
          if (a_max) alu_op <= alu_op + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sweep_gen.sv
// Directed bench for alu_sweep_gen with a 2-bit adder as the ALU under test.
module tb_alu_sweep_gen;
  localparam int W = 2, OB = 2, ST = 2, OPB = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  alu_a, alu_b, alu_o;
  logic [OB-1:0] alu_op, out_block;
  logic [7:0]    alu_flags;
  logic [9:0]    out_data;
  logic          out_valid, out_last_block, busy, done;

  alu_sweep_gen #(.WIDTH(W), .OP_BITS(OB), .SETTLE(ST), .OPS_PER_BLOCK(OPB)) dut (
    .clk(clk), ._reset(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
    .alu_flags(alu_flags), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last_block(out_last_block),
    .out_block(out_block), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ALU model: o = a+b mod 4, flags tag the operands so every word is unique
  assign alu_o     = alu_a + alu_b;
  assign alu_flags = {alu_op, alu_a, alu_b, ~alu_op};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_data(input int idx);
    logic [5:0] i;
    logic [1:0] op, a, b;
    i  = idx[5:0];
    op = i[5:4]; a = i[3:2]; b = i[1:0];
    return {op, a, b, ~op, 2'(a + b)};
  endfunction

  // monitor: log transfers, stall cycles and done pulses at the falling edge
  int         cyc = 0, words = 0, base = 0;
  int         done_cnt = 0, done_cyc = 0, stall_seen = 0, stall_bad = 0;
  logic [9:0] stall_last = '0;
  logic [9:0] log_data [256];
  logic       log_last [256];
  logic [1:0] log_blk  [256];
  int         log_cyc  [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !abort) begin
      if (words < 256) begin
        log_data[words] = out_data;
        log_last[words] = out_last_block;
        log_blk[words]  = out_block;
        log_cyc[words]  = cyc;
      end
      words++;
    end
    if (rst_n && out_valid && !out_ready) begin
      stall_seen++;
      stall_last = out_data;
      if (out_data !== model_data(words - base)) stall_bad++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (words < n && k < budget) begin step(); k++; end
    chk(name, words, n);
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin step(); k++; end
    chk(name, done_cnt - d0, 1);
  endtask

  task automatic check_sweep(input int b0, input string tag);
    int de = 0, le = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_data[b0+i] !== model_data(i)) de++;
      if (log_last[b0+i] !== (i == 31 || i == 63)) le++;
      if (log_blk[b0+i] !== ((i < 32) ? 2'd0 : 2'd1)) le++;
    end
    chk({tag, "_data_errs"}, de, 0);
    chk({tag, "_last_block_errs"}, le, 0);
  endtask

  typedef struct {
    int         idx;
    logic [9:0] data;
    logic       last;
    logic [1:0] blk;
  } vec_t;
  vec_t tv [8];

  initial begin
    int s_cyc, d0, sp_bad, k;
    logic pulsed;
    tv[0] = '{0,  10'h00C, 1'b0, 2'd0};
    tv[1] = '{7,  10'h07C, 1'b0, 2'd0};
    tv[2] = '{8,  10'h08E, 1'b0, 2'd0};
    tv[3] = '{10, 10'h0AC, 1'b0, 2'd0};
    tv[4] = '{31, 10'h1FA, 1'b1, 2'd0};
    tv[5] = '{32, 10'h204, 1'b0, 2'd1};
    tv[6] = '{47, 10'h2F6, 1'b0, 2'd1};
    tv[7] = '{63, 10'h3F2, 1'b1, 2'd1};

    repeat (3) step();
    chk("reset_outputs", {alu_a, alu_b, alu_op, out_data, out_valid,
                          out_last_block, out_block, busy, done}, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_start_on_release", busy, 0);

    // clean sweep, out_ready held high
    base = words; s_cyc = cyc; d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    wait_done(d0, 400, "runA_done_pulses");
    chk("runA_words", words - base, 64);
    chk("runA_first_latency", log_cyc[base] - s_cyc, 3);
    sp_bad = 0;
    for (int i = 1; i < 64; i++)
      if (log_cyc[base+i] - log_cyc[base+i-1] != 4) sp_bad++;
    chk("runA_spacing_errs", sp_bad, 0);
    chk("runA_done_latency", done_cyc - log_cyc[base+63], 2);
    chk("runA_idle_after", {busy, done, out_valid}, 0);
    check_sweep(base, "runA");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_data", tv[i].idx), log_data[base+tv[i].idx], tv[i].data);
      chk($sformatf("vec%0d_last", tv[i].idx), log_last[base+tv[i].idx], tv[i].last);
      chk($sformatf("vec%0d_block", tv[i].idx), log_blk[base+tv[i].idx], tv[i].blk);
    end

    // stall 5 cycles on word 7, stray start at word 5
    base = words; d0 = done_cnt; k = 0; pulsed = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    while (done_cnt == d0 && k < 500) begin
      start = (!pulsed && out_valid && (words - base) == 5);
      if (start) pulsed = 1'b1;
      out_ready = !(out_valid && (words - base) == 7 && stall_seen < 5);
      step(); k++;
    end
    out_ready = 1'b1; start = 1'b0;
    chk("runB_done_pulses", done_cnt - d0, 1);
    chk("runB_start_pulsed", pulsed, 1);
    chk("runB_words", words - base, 64);
    chk("runB_stall_cycles", stall_seen, 5);
    chk("runB_stall_unstable", stall_bad, 0);
    chk("runB_stall_data", stall_last, 10'h07C);
    chk("runB_after_stall", log_data[base+8], 10'h08E);
    check_sweep(base, "runB");

    // abort coincident with a transfer on word 10
    base = words;
    start = 1'b1; step(); start = 1'b0;
    wait_words(base + 10, 100, "runC_reach_word10");
    k = 0;
    while (!out_valid && k < 10) begin step(); k++; end
    chk("runC_in_emit", out_valid, 1);
    d0 = done_cnt;
    abort = 1'b1; step(); abort = 1'b0;
    chk("runC_abort_idle", {busy, out_valid}, 0);
    chk("runC_no_transfer", words - base, 10);
    repeat (4) step();
    chk("runC_no_done", done_cnt - d0, 0);
    base = words;
    start = 1'b1; step(); start = 1'b0;
    wait_words(base + 1, 20, "runC_restart_word");
    chk("runC_restart_data", log_data[base], 10'h00C);
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    // asynchronous reset in SETTLE of word 20
    base = words;
    start = 1'b1; step(); start = 1'b0;
    wait_words(base + 20, 200, "runD_reach_word20");
    step();
    chk("runD_pre_reset", {busy, alu_op, alu_a, alu_b}, 7'b1_01_01_00);
    #1 rst_n = 1'b0;
    #1 chk("runD_async_reset", {alu_a, alu_b, alu_op, out_data, out_valid,
                                 out_last_block, out_block, busy, done}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("runD_no_start_on_release", busy, 0);
    base = words;
    start = 1'b1; step(); start = 1'b0;
    wait_words(base + 1, 20, "runD_restart_word");
    chk("runD_restart_data", log_data[base], 10'h00C);
    abort = 1'b1; step(); abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
